// File: rtl/tug_referee_pkg.sv
// tug_pkg: shared state encoding, rope geometry and LED decode for the tug-of-war referee.
package tug_pkg;
  typedef enum logic [1:0] {ARM, SETTLE, WIN} state_t;
  localparam int NPOS = 7;
  localparam logic [2:0] CENTER = 3'd3;
  localparam logic [2:0] LEFT_END = 3'd0;
  localparam logic [2:0] RIGHT_END = 3'd6;
  function automatic logic [NPOS-1:0] one_hot(input logic [2:0] p);
    return NPOS'(1) << p;
  endfunction
endpackage

// File: rtl/tug_referee_if.sv
// tug_referee_if: button-latch results, raw button levels and referee outputs.
interface tug_referee_if;
  import tug_pkg::*;
  logic push;
  logic tie;
  logic right;
  logic pbl;
  logic pbr;
  logic clear;
  logic [NPOS-1:0] leds;
  logic win_left;
  logic win_right;
  modport master(output push, tie, right, pbl, pbr, input clear, leds, win_left, win_right);
  modport slave(input push, tie, right, pbl, pbr, output clear, leds, win_left, win_right);
endinterface

// File: rtl/tug_referee_release_timer.sv
// release_timer: pulses done on the cycle that completes RELEASE_CYCLES consecutive idle cycles.
module release_timer #(
  parameter int RELEASE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic idle,
  output logic done
);
  logic [7:0] cnt;
  assign done = en && idle && cnt == 8'(RELEASE_CYCLES - 1);
  always_ff @(posedge clk) begin
    cnt <= (rst || !en || !idle || done) ? '0 : cnt + 8'd1;
  end
endmodule

// File: rtl/tug_referee.sv
// tug_referee: referee FSM moving the rope one step per latched press and declaring a winner.
module tug_referee
  import tug_pkg::*;
#(
  parameter int RELEASE_CYCLES = 4
) (
  input logic clk,
  input logic rst,
  tug_referee_if.slave bus
);
  state_t state;
  logic [2:0] pos;
  logic [2:0] pos_nxt;
  logic at_end;
  logic settling;
  logic idle;
  logic done;
  assign settling = state == SETTLE;
  assign idle = !bus.pbl && !bus.pbr;
  release_timer #(.RELEASE_CYCLES(RELEASE_CYCLES)) u_timer (
    .clk(clk),
    .rst(rst),
    .en(settling),
    .idle(idle),
    .done(done)
  );
  always_comb begin
    at_end = bus.right ? pos == RIGHT_END : pos == LEFT_END;
    pos_nxt = bus.right ? pos + 3'd1 : pos - 3'd1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= SETTLE;
      pos <= CENTER;
      bus.clear <= 1'b1;
      bus.leds <= one_hot(CENTER);
      bus.win_left <= 1'b0;
      bus.win_right <= 1'b0;
    end else begin
      case (state)
        ARM: begin
          if (bus.tie) begin
            state <= SETTLE;
            bus.clear <= 1'b1;
          end else if (bus.push && at_end) begin
            state <= WIN;
            bus.clear <= 1'b1;
            bus.leds <= '1;
            bus.win_right <= bus.right;
            bus.win_left <= !bus.right;
          end else if (bus.push) begin
            state <= SETTLE;
            bus.clear <= 1'b1;
            pos <= pos_nxt;
            bus.leds <= one_hot(pos_nxt);
          end
        end
        SETTLE: begin
          if (done) begin
            state <= ARM;
            bus.clear <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_tug_referee.sv
// tb_tug_referee: directed scenarios checked every cycle against a rule-level game model.
module tb_tug_referee;
  localparam int RC = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  tug_referee_if bus ();
  tug_referee #(.RELEASE_CYCLES(RC)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );
  always #5 clk = ~clk;
  int m_pos;
  int m_mode;
  int m_run;
  bit m_wl;
  bit m_wr;
  bit m_ok = 1'b0;
  always @(posedge clk) begin
    if (rst) begin
      m_pos = 3;
      m_mode = 1;
      m_run = 0;
      m_wl = 0;
      m_wr = 0;
      m_ok = 1;
    end else if (m_ok) begin
      if (m_mode == 0) begin
        if (bus.tie) m_mode = 1;
        else if (bus.push && bus.right) begin
          if (m_pos == 6) begin m_mode = 2; m_wr = 1; end
          else begin m_pos = m_pos + 1; m_mode = 1; end
        end else if (bus.push) begin
          if (m_pos == 0) begin m_mode = 2; m_wl = 1; end
          else begin m_pos = m_pos - 1; m_mode = 1; end
        end
        m_run = 0;
      end else if (m_mode == 1) begin
        m_run = (bus.pbl || bus.pbr) ? 0 : m_run + 1;
        if (m_run == RC) begin m_mode = 0; m_run = 0; end
      end
    end
  end
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    if (m_ok) begin
      chk("model_leds", 32'(bus.leds), m_mode == 2 ? 32'h7f : 32'(1) << m_pos);
      chk("model_clear", 32'(bus.clear), 32'(m_mode != 0));
      chk("model_win_left", 32'(bus.win_left), 32'(m_wl));
      chk("model_win_right", 32'(bus.win_right), 32'(m_wr));
      chk("wins_exclusive", 32'(bus.win_left && bus.win_right), 32'd0);
    end
  end
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic press(input logic r);
    bus.push = 1;
    bus.right = r;
    if (r) bus.pbr = 1;
    else bus.pbl = 1;
    tick(1);
    bus.push = 0;
    tick(1);
    bus.pbl = 0;
    bus.pbr = 0;
    tick(RC);
  endtask
  initial begin
    bus.push = 0;
    bus.tie = 0;
    bus.right = 0;
    bus.pbl = 0;
    bus.pbr = 0;
    tick(1);
    chk("reset_leds", 32'(bus.leds), 32'h08);
    chk("reset_clear", 32'(bus.clear), 32'd1);
    chk("reset_wins", 32'({bus.win_left, bus.win_right}), 32'd0);
    rst = 0;
    tick(3);
    chk("arm_not_yet", 32'(bus.clear), 32'd1);
    tick(1);
    chk("arm_after_4", 32'(bus.clear), 32'd0);
    bus.push = 1;
    bus.right = 1;
    bus.pbr = 1;
    tick(1);
    chk("right_step_leds", 32'(bus.leds), 32'h10);
    chk("right_step_clear", 32'(bus.clear), 32'd1);
    bus.push = 0;
    tick(2);
    bus.pbr = 0;
    tick(3);
    chk("settle_3_idle", 32'(bus.clear), 32'd1);
    tick(1);
    chk("settle_4_idle", 32'(bus.clear), 32'd0);
    press(1);
    chk("pos5_leds", 32'(bus.leds), 32'h20);
    bus.tie = 1;
    bus.push = 1;
    bus.pbl = 1;
    bus.pbr = 1;
    tick(1);
    chk("tie_leds", 32'(bus.leds), 32'h20);
    chk("tie_clear", 32'(bus.clear), 32'd1);
    bus.tie = 0;
    bus.push = 0;
    bus.pbl = 0;
    bus.pbr = 0;
    tick(2);
    bus.pbl = 1;
    tick(1);
    bus.pbl = 0;
    tick(3);
    chk("restart_count", 32'(bus.clear), 32'd1);
    tick(1);
    chk("restart_done", 32'(bus.clear), 32'd0);
    rst = 1;
    tick(1);
    rst = 0;
    tick(RC);
    press(0);
    press(0);
    press(0);
    chk("left_end_leds", 32'(bus.leds), 32'h01);
    bus.push = 1;
    bus.right = 0;
    bus.pbl = 1;
    tick(1);
    chk("win_left", 32'(bus.win_left), 32'd1);
    chk("win_left_leds", 32'(bus.leds), 32'h7f);
    bus.right = 1;
    bus.tie = 1;
    bus.pbl = 0;
    tick(6);
    chk("win_sticky_left", 32'(bus.win_left), 32'd1);
    chk("win_sticky_right", 32'(bus.win_right), 32'd0);
    chk("win_clear", 32'(bus.clear), 32'd1);
    bus.tie = 0;
    bus.pbr = 1;
    rst = 1;
    tick(1);
    chk("rst_in_win_leds", 32'(bus.leds), 32'h08);
    chk("rst_in_win_flags", 32'({bus.win_left, bus.win_right}), 32'd0);
    rst = 0;
    tick(20);
    chk("held_thru_reset", 32'(bus.leds), 32'h08);
    bus.push = 0;
    bus.pbr = 0;
    tick(RC);
    chk("rearm_after_hold", 32'(bus.clear), 32'd0);
    bus.push = 1;
    bus.right = 1;
    bus.pbr = 1;
    tick(50);
    bus.push = 0;
    bus.pbr = 0;
    tick(RC);
    chk("held_one_step", 32'(bus.leds), 32'h10);
    press(1);
    press(1);
    chk("right_end_leds", 32'(bus.leds), 32'h40);
    bus.push = 1;
    bus.right = 1;
    tick(1);
    chk("win_right", 32'(bus.win_right), 32'd1);
    chk("win_right_only", 32'(bus.win_left), 32'd0);
    chk("win_right_leds", 32'(bus.leds), 32'h7f);
    bus.push = 0;
    tick(3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
